// File: rtl/aes_key_sched_ctrl_128_if.sv
// Key-schedule controller bus.
// Purpose: groups the key-load handshake, abort/status and round-key read port.
// Signals:
//   key_valid/key_ready/key_in : key load handshake, w0 = key_in[127:96]
//   abort                      : cancel expansion / invalidate stored keys
//   busy/done/rk_valid         : controller status
//   rk_rd_idx/rk_rd_data       : registered round-key read port (1-cycle latency)
// Modports: master = key-load / round-engine side, slave = controller.
interface aes_key_sched_ctrl_128_if #(
    parameter int IDX_W = 4
);
    logic             key_valid;
    logic             key_ready;
    logic [127:0]     key_in;
    logic             abort;
    logic             busy;
    logic             done;
    logic             rk_valid;
    logic [IDX_W-1:0] rk_rd_idx;
    logic [127:0]     rk_rd_data;

    modport master (
        output key_valid, key_in, abort, rk_rd_idx,
        input  key_ready, busy, done, rk_valid, rk_rd_data
    );

    modport slave (
        input  key_valid, key_in, abort, rk_rd_idx,
        output key_ready, busy, done, rk_valid, rk_rd_data
    );
endinterface

// File: rtl/aes_key_sched_ctrl_128.sv
// Sequential AES-128 key-schedule controller.
// Purpose: accepts a cipher key, runs one key-expansion step per clock for NR
//   rounds and stores rk[0..NR] in an internal register file readable through
//   a registered read port.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : aes_key_sched_ctrl_128_if.slave (handshake, abort, status, read port)
// Configuration:
//   AES_KS_ZEROIZE_EN : when defined, abort also clears all stored round keys
//                       and the working key on the same edge.

// One AES-128 key expansion round: rk[r] = expand(rk[r-1], rcon).
module aes_key_expand_128 (
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] key_out
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed arithmetically: inverse as x^254 = x^2*x^4*...*x^128
    // (maps 0 to 0), followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot;
    logic [31:0] temp;
    logic [31:0] w4, w5, w6, w7;

    always_comb begin
        w0   = key_in[127:96];
        w1   = key_in[95:64];
        w2   = key_in[63:32];
        w3   = key_in[31:0];
        rot  = {w3[23:0], w3[31:24]};
        temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon, 24'h000000};
        w4   = w0 ^ temp;
        w5   = w1 ^ w4;
        w6   = w2 ^ w5;
        w7   = w3 ^ w6;
        key_out = {w4, w5, w6, w7};
    end
endmodule

module aes_key_sched_ctrl_128 #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    aes_key_sched_ctrl_128_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [3:0]   rnd;
    logic [7:0]   rcon;
    logic [127:0] cur_key;
    logic [127:0] next_key;
    logic [127:0] entry [0:NR];
    logic [127:0] rd_next;
    logic         accept;
    logic         last_round;
    logic         done_q;
    logic         rk_valid_q;
    logic [127:0] rd_data_q;

    aes_key_expand_128 u_expand (
        .key_in  (cur_key),
        .rcon    (rcon),
        .key_out (next_key)
    );

    // key_ready is independent of abort; abort only blocks acceptance.
    assign bus.key_ready = (state != EXPAND);
    assign bus.busy      = (state == EXPAND);
    assign bus.done      = done_q;
    assign bus.rk_valid  = rk_valid_q;
    assign bus.rk_rd_data = rd_data_q;

    assign accept     = bus.key_valid & bus.key_ready & ~bus.abort;
    assign last_round = (state == EXPAND) && (rnd == 4'(NR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = EXPAND;
                EXPAND:  if (last_round) state_next = READY;
                READY:   if (accept) state_next = EXPAND;
                default: state_next = IDLE;
            endcase
        end
    end

    // Read mux: indices beyond NR fall through to zero.
    always_comb begin
        rd_next = '0;
        for (int unsigned i = 0; i <= NR; i++) begin
            if (bus.rk_rd_idx == IDX_W'(i)) rd_next = entry[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd        <= '0;
            rcon       <= 8'h01;
            cur_key    <= '0;
            done_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            for (int unsigned i = 0; i <= NR; i++) entry[i] <= '0;
        end else if (bus.abort) begin
            rnd        <= '0;
            rcon       <= 8'h01;
            done_q     <= 1'b0;
            rk_valid_q <= 1'b0;
`ifdef AES_KS_ZEROIZE_EN
            cur_key    <= '0;
            for (int unsigned i = 0; i <= NR; i++) entry[i] <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                entry[0]   <= bus.key_in;
                cur_key    <= bus.key_in;
                rnd        <= 4'd1;
                rcon       <= 8'h01;
                rk_valid_q <= 1'b0;
            end else if (state == EXPAND) begin
                for (int unsigned i = 1; i <= NR; i++) begin
                    if (rnd == 4'(i)) entry[i] <= next_key;
                end
                cur_key <= next_key;
                rcon    <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                rnd     <= rnd + 4'd1;
                if (last_round) begin
                    rk_valid_q <= 1'b1;
                    done_q     <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_key_sched_ctrl_128.sv
module tb_aes_key_sched_ctrl_128;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] rkm [0:10];
    logic [127:0] mem [0:10];

    aes_key_sched_ctrl_128_if #(.IDX_W(4)) bus ();

    aes_key_sched_ctrl_128 #(.NR(10), .IDX_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from exp/log tables over generator 3, then bitwise affine map.
    task automatic build_sbox();
        logic [7:0] ex [0:254];
        int         lg [0:255];
        logic [7:0] e;
        logic [7:0] b;
        logic [7:0] s;
        logic [7:0] c;
        e = 8'h01;
        for (int i = 0; i < 256; i++) lg[i] = 0;
        for (int i = 0; i < 255; i++) begin
            ex[i] = e;
            lg[e] = i;
            e = e ^ xt(e);
        end
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            b = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
            for (int i = 0; i < 8; i++)
                s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8]
                       ^ b[(i + 7) % 8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    // FIPS-197 word-oriented key expansion into rkm[0..10].
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = k[127:96];
        w[1] = k[95:64];
        w[2] = k[63:32];
        w[3] = k[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rkm[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic sweep(input string tag);
        logic [127:0] exp;
        for (int i = 0; i < 16; i++) begin
            bus.rk_rd_idx = 4'(i);
            step();
            exp = (i <= 10) ? mem[i] : 128'h0;
            chk($sformatf("%s_rd%0d", tag, i), bus.rk_rd_data, exp);
        end
    endtask

    // Waits for done after an acceptance edge; returns edges counted from E0.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 128'(bus.done), 128'h1);
    endtask

    task automatic expand_key(input logic [127:0] k, input string tag);
        int n;
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        step();
        bus.key_valid = 1'b0;
        chk({tag, "_busy"}, 128'(bus.busy), 128'h1);
        chk({tag, "_ready_lo"}, 128'(bus.key_ready), 128'h0);
        wait_done(tag, n);
        chk({tag, "_latency"}, 128'(n + 1), 128'd11);
        chk({tag, "_rkvalid"}, 128'(bus.rk_valid), 128'h1);
        step();
        chk({tag, "_done_pulse"}, 128'(bus.done), 128'h0);
        model_expand(k);
        for (int i = 0; i < 11; i++) mem[i] = rkm[i];
        sweep(tag);
    endtask

    initial begin
        logic [127:0] k1, k2, k3;
        logic [127:0] old7;
        int n;
        vectors = 0;
        miscompares = 0;
        build_sbox();
        for (int i = 0; i < 11; i++) mem[i] = '0;

        rst_n = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_in = '0;
        bus.abort = 1'b0;
        bus.rk_rd_idx = '0;
        #13;
        chk("rst_ready", 128'(bus.key_ready), 128'h1);
        chk("rst_busy", 128'(bus.busy), 128'h0);
        chk("rst_done", 128'(bus.done), 128'h0);
        chk("rst_rkvalid", 128'(bus.rk_valid), 128'h0);
        chk("rst_rddata", bus.rk_rd_data, 128'h0);
        rst_n = 1'b1;
        step();
        sweep("rst");

        // FIPS-197 vector
        expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c, "fips");
        bus.rk_rd_idx = 4'd1;
        step();
        chk("fips_rk1", bus.rk_rd_data, 128'ha0fafe1788542cb123a339392a6c7605);
        bus.rk_rd_idx = 4'd10;
        step();
        chk("fips_rk10", bus.rk_rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        bus.rk_rd_idx = 4'd0;
        step();
        chk("fips_rk0", bus.rk_rd_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);

        for (int t = 0; t < 3; t++)
            expand_key({$urandom, $urandom, $urandom, $urandom}, $sformatf("rnd%0d", t));

        // key_valid held through EXPAND: one acceptance, then second key in READY
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        bus.key_in = k1;
        bus.key_valid = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold_ready_lo%0d", i), 128'(bus.key_ready), 128'h0);
            bus.key_in = (i == 9) ? k2 : {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        chk("hold_done", 128'(bus.done), 128'h1);
        chk("hold_rkvalid", 128'(bus.rk_valid), 128'h1);
        chk("hold_ready_hi", 128'(bus.key_ready), 128'h1);
        model_expand(k1);
        old7 = rkm[7];
        bus.rk_rd_idx = 4'd7;
        step();
        bus.key_valid = 1'b0;
        chk("hold2_rkvalid_drop", 128'(bus.rk_valid), 128'h0);
        chk("hold2_busy", 128'(bus.busy), 128'h1);
        step();
        chk("hold2_stale_rk7", bus.rk_rd_data, old7);
        wait_done("hold2", n);
        chk("hold2_latency", 128'(n + 2), 128'd11);
        model_expand(k2);
        for (int i = 0; i < 11; i++) mem[i] = rkm[i];
        step();
        sweep("hold2");

        // abort at round 5
        k3 = {$urandom, $urandom, $urandom, $urandom};
        bus.key_in = k3;
        bus.key_valid = 1'b1;
        step();
        bus.key_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abt5_ready", 128'(bus.key_ready), 128'h1);
        chk("abt5_busy", 128'(bus.busy), 128'h0);
        chk("abt5_rkvalid", 128'(bus.rk_valid), 128'h0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) n++;
            step();
        end
        chk("abt5_no_done", 128'(n), 128'h0);
        model_expand(k3);
`ifdef AES_KS_ZEROIZE_EN
        for (int i = 0; i < 11; i++) mem[i] = '0;
`else
        for (int i = 0; i < 5; i++) mem[i] = rkm[i];
`endif
        sweep("abt5");

        // abort with key_valid in READY
        expand_key({$urandom, $urandom, $urandom, $urandom}, "pre_abt");
        bus.key_in = {$urandom, $urandom, $urandom, $urandom};
        bus.key_valid = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.key_valid = 1'b0;
        bus.abort = 1'b0;
        chk("abtacc_busy", 128'(bus.busy), 128'h0);
        chk("abtacc_ready", 128'(bus.key_ready), 128'h1);
        chk("abtacc_rkvalid", 128'(bus.rk_valid), 128'h0);
`ifdef AES_KS_ZEROIZE_EN
        for (int i = 0; i < 11; i++) mem[i] = '0;
`endif
        sweep("abtacc");

        // abort on the completion edge E10
        k1 = {$urandom, $urandom, $urandom, $urandom};
        bus.key_in = k1;
        bus.key_valid = 1'b1;
        step();
        bus.key_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abt10_done", 128'(bus.done), 128'h0);
        chk("abt10_rkvalid", 128'(bus.rk_valid), 128'h0);
        chk("abt10_busy", 128'(bus.busy), 128'h0);
        model_expand(k1);
`ifdef AES_KS_ZEROIZE_EN
        for (int i = 0; i < 11; i++) mem[i] = '0;
`else
        for (int i = 0; i < 10; i++) mem[i] = rkm[i];
`endif
        sweep("abt10");

        // asynchronous reset mid-EXPAND
        bus.key_in = {$urandom, $urandom, $urandom, $urandom};
        bus.key_valid = 1'b1;
        bus.rk_rd_idx = 4'd0;
        step();
        bus.key_valid = 1'b0;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 128'(bus.key_ready), 128'h1);
        chk("arst_busy", 128'(bus.busy), 128'h0);
        chk("arst_done", 128'(bus.done), 128'h0);
        chk("arst_rkvalid", 128'(bus.rk_valid), 128'h0);
        chk("arst_rddata", bus.rk_rd_data, 128'h0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) mem[i] = '0;
        step();
        chk("arst_no_done", 128'(bus.done), 128'h0);
        sweep("arst");
        expand_key(128'h0, "zero");
        bus.rk_rd_idx = 4'd10;
        step();
        chk("zero_rk10", bus.rk_rd_data, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
